// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register-bank slave with byte strobes and SLVERR on out-of-window access
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int DEPTH      = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [RESP_WIDTH-1:0] OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) >= BASE_ADDR && int'(a) < BASE_ADDR + 4 * DEPTH;
    endfunction

    function automatic logic [IW-1:0] index(input logic [ADDR_WIDTH-1:0] a);
        return IW'((int'(a) - BASE_ADDR) / 4);
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]         w_strb_q;
    logic                  awready_q, wready_q, arready_q;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  aw_fire, w_fire, ar_fire, commit, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_strb;
    logic                  unused_strb_msb;

    assign unused_strb_msb = s_axi_wstrb[NB];

    // The write commits on whichever edge completes the AW/W pair, taking each half from its holding register or the bus.
    always_comb begin
        aw_fire   = s_axi_awvalid & awready_q;
        w_fire    = s_axi_wvalid & wready_q;
        ar_fire   = s_axi_arvalid & arready_q;
        wr_addr   = aw_held_q ? aw_addr_q : s_axi_awaddr;
        wr_data   = w_held_q ? w_data_q : s_axi_wdata;
        wr_strb   = w_held_q ? w_strb_q : s_axi_wstrb[NB-1:0];
        commit    = (aw_held_q | aw_fire) & (w_held_q | w_fire);
        wr_ok     = in_range(wr_addr);
        rd_ok     = in_range(s_axi_araddr);
        aw_held_d = ~commit & (aw_held_q | aw_fire);
        w_held_d  = ~commit & (w_held_q | w_fire);
        bvalid_d  = commit | (bvalid_q & ~s_axi_bready);
        bresp_d   = commit ? (wr_ok ? OKAY : SLVERR) : bresp_q;
        rvalid_d  = ar_fire | (rvalid_q & ~s_axi_rready);
        rresp_d   = ar_fire ? (rd_ok ? OKAY : SLVERR) : rresp_q;
        rdata_d   = ar_fire ? (rd_ok ? regs_q[index(s_axi_araddr)] : '0) : rdata_q;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            if (aw_fire) aw_addr_q <= s_axi_awaddr;
            if (w_fire) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb[NB-1:0];
            end
            awready_q <= ~aw_held_d & ~bvalid_d;
            wready_q  <= ~w_held_d & ~bvalid_d;
            arready_q <= ~rvalid_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            if (commit && wr_ok)
                for (int b = 0; b < NB; b++)
                    if (wr_strb[b]) regs_q[index(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed checks of two register-slave windows (base 0 and base 16) sharing one stimulus bus
module tb_axil_reg_slave;
    logic        clk = 0, rst = 1;
    logic [7:0]  awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0;
    logic [4:0]  wstrb = 0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready0, wready0, bvalid0, arready0, rvalid0;
    logic        awready1, wready1, bvalid1, arready1, rvalid1;
    logic [2:0]  bresp0, rresp0, bresp1, rresp1;
    logic [31:0] rdata0, rdata1;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(.BASE_ADDR(0)) dut0 (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready0),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready0),
        .s_axi_bresp(bresp0), .s_axi_bvalid(bvalid0), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready0),
        .s_axi_rdata(rdata0), .s_axi_rresp(rresp0), .s_axi_rvalid(rvalid0), .s_axi_rready(rready)
    );

    axil_reg_slave #(.BASE_ADDR(16)) dut1 (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready1),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready1),
        .s_axi_bresp(bresp1), .s_axi_bvalid(bvalid1), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready1),
        .s_axi_rdata(rdata1), .s_axi_rresp(rresp1), .s_axi_rvalid(rvalid1), .s_axi_rready(rready)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                            output logic [2:0] r0, output logic [2:0] r1);
        logic ah, wh;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while ((awvalid || wvalid) && n < 20) begin
            ah = awvalid && awready0;
            wh = wvalid && wready0;
            step;
            if (ah) awvalid = 0;
            if (wh) wvalid = 0;
            n++;
        end
        while (!bvalid0 && n < 40) begin
            step;
            n++;
        end
        checks++;
        if (!bvalid0) begin
            errors++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid0);
        end
        r0 = bresp0; r1 = bresp1;
        awvalid = 0; wvalid = 0;
        step;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d0, output logic [2:0] rr0,
                           output logic [31:0] d1, output logic [2:0] rr1);
        logic hs;
        int n = 0;
        araddr = a; arvalid = 1; rready = 1;
        while (arvalid && n < 20) begin
            hs = arready0;
            step;
            if (hs) arvalid = 0;
            n++;
        end
        while (!rvalid0 && n < 40) begin
            step;
            n++;
        end
        checks++;
        if (!rvalid0) begin
            errors++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid0);
        end
        d0 = rdata0; rr0 = rresp0; d1 = rdata1; rr1 = rresp1;
        arvalid = 0;
        step;
    endtask

    task automatic test_reset;
        rst = 1;
        step;
        step;
        checks++;
        if ({awready0, wready0, arready0, bvalid0, rvalid0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {awready0, wready0, arready0, bvalid0, rvalid0});
        end
        checks++;
        if ({rdata0, bresp0, rresp0} !== 38'b0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h bresp=%0d rresp=%0d required 0", rdata0, bresp0, rresp0);
        end
        rst = 0;
        step;
        checks++;
        if ({awready0, wready0, arready0} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_readies: got %b required 111", {awready0, wready0, arready0});
        end
    endtask

    task automatic test_basic;
        awaddr = 8'h00; wdata = 56; wstrb = 5'h0F; awvalid = 1; wvalid = 1; bready = 1;
        step;
        awvalid = 0; wvalid = 0;
        checks++;
        if ({bvalid0, bresp0, awready0, wready0} !== 6'b1_000_00) begin
            errors++;
            $display("FAIL basic_b: bvalid=%b bresp=%0d awready=%b wready=%b required 1 0 0 0", bvalid0, bresp0, awready0, wready0);
        end
        step;
        checks++;
        if ({bvalid0, awready0, wready0} !== 3'b011) begin
            errors++;
            $display("FAIL basic_b_done: bvalid=%b awready=%b wready=%b required 0 1 1", bvalid0, awready0, wready0);
        end
        araddr = 8'h00; arvalid = 1; rready = 1;
        step;
        arvalid = 0;
        checks++;
        if ({rvalid0, arready0, rresp0} !== 5'b10_000 || rdata0 !== 32'd56) begin
            errors++;
            $display("FAIL basic_read: rvalid=%b arready=%b rresp=%0d rdata=%0d required 1 0 0 56", rvalid0, arready0, rresp0, rdata0);
        end
        step;
        checks++;
        if ({rvalid0, arready0} !== 2'b01) begin
            errors++;
            $display("FAIL basic_read_done: rvalid=%b arready=%b required 0 1", rvalid0, arready0);
        end
    endtask

    task automatic test_strobe;
        logic [2:0] r0, r1, rr0, rr1;
        logic [31:0] d0, d1;
        do_write(8'h04, 32'hAABBCCDD, 5'h0F, r0, r1);
        do_write(8'h04, 32'h11223344, 5'h15, r0, r1);
        checks++;
        if (r0 !== 3'd0) begin
            errors++;
            $display("FAIL strobe_bresp: got %0d required 0", r0);
        end
        do_read(8'h04, d0, rr0, d1, rr1);
        checks++;
        if (d0 !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL strobe_merge: got %h required aa22cc44", d0);
        end
        do_write(8'h04, 32'hFFFFFFFF, 5'h00, r0, r1);
        do_read(8'h04, d0, rr0, d1, rr1);
        checks++;
        if (r0 !== 3'd0 || d0 !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL strobe_zero: bresp=%0d rdata=%h required 0 aa22cc44", r0, d0);
        end
    endtask

    task automatic test_aw_first;
        logic [2:0] rr0, rr1;
        logic [31:0] d0, d1;
        awaddr = 8'h08; awvalid = 1; wvalid = 0; bready = 1;
        checks++;
        if (awready0 !== 1'b1) begin
            errors++;
            $display("FAIL awfirst_ready: awready=%b required 1", awready0);
        end
        step;
        awvalid = 0;
        step;
        step;
        checks++;
        if ({awready0, wready0, bvalid0} !== 3'b010) begin
            errors++;
            $display("FAIL awfirst_hold: awready=%b wready=%b bvalid=%b required 0 1 0", awready0, wready0, bvalid0);
        end
        wdata = 64; wstrb = 5'h0F; wvalid = 1;
        step;
        wvalid = 0;
        checks++;
        if ({bvalid0, bresp0} !== 4'b1_000) begin
            errors++;
            $display("FAIL awfirst_b: bvalid=%b bresp=%0d required 1 0", bvalid0, bresp0);
        end
        step;
        do_read(8'h08, d0, rr0, d1, rr1);
        checks++;
        if (d0 !== 32'd64) begin
            errors++;
            $display("FAIL awfirst_readback: got %0d required 64", d0);
        end
    endtask

    task automatic test_oob;
        logic [2:0] r0, r1, rr0, rr1;
        logic [31:0] d0, d1, a0, a4, a8;
        do_write(8'h10, 32'hDEADBEEF, 5'h0F, r0, r1);
        checks++;
        if (r0 !== 3'd2) begin
            errors++;
            $display("FAIL oob_bresp: got %0d required 2", r0);
        end
        do_read(8'h10, d0, rr0, d1, rr1);
        checks++;
        if (rr0 !== 3'd2 || d0 !== 32'd0) begin
            errors++;
            $display("FAIL oob_read: rresp=%0d rdata=%h required 2 0", rr0, d0);
        end
        do_read(8'h00, a0, rr0, d1, rr1);
        do_read(8'h04, a4, rr0, d1, rr1);
        do_read(8'h08, a8, rr0, d1, rr1);
        checks++;
        if ({a0, a4, a8} !== {32'd56, 32'hAA22CC44, 32'd64}) begin
            errors++;
            $display("FAIL oob_untouched: got %h %h %h required 38 aa22cc44 40", a0, a4, a8);
        end
    endtask

    task automatic test_backpressure;
        awaddr = 8'h0C; wdata = 32'h12345678; wstrb = 5'h0F; awvalid = 1; wvalid = 1; bready = 0;
        step;
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid0, bresp0, awready0, wready0} !== 6'b1_000_00) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: bvalid=%b bresp=%0d awready=%b wready=%b required 1 0 0 0", i, bvalid0, bresp0, awready0, wready0);
            end
            step;
        end
        bready = 1;
        step;
        checks++;
        if ({bvalid0, awready0, wready0} !== 3'b011) begin
            errors++;
            $display("FAIL bp_release: bvalid=%b awready=%b wready=%b required 0 1 1", bvalid0, awready0, wready0);
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] rr0, rr1;
        logic [31:0] d0, d1;
        awaddr = 8'h00; wdata = 99; wstrb = 5'h0F; awvalid = 1; wvalid = 1; bready = 0;
        araddr = 8'h04; arvalid = 1; rready = 0;
        step;
        awvalid = 0; wvalid = 0; arvalid = 0;
        checks++;
        if ({bvalid0, rvalid0} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pending: bvalid=%b rvalid=%b required 1 1", bvalid0, rvalid0);
        end
        rst = 1;
        step;
        checks++;
        if ({bvalid0, rvalid0, awready0, wready0, arready0} !== 5'b0 || rdata0 !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_cleared: ctrl=%b rdata=%h required 00000 0", {bvalid0, rvalid0, awready0, wready0, arready0}, rdata0);
        end
        rst = 0; bready = 1; rready = 1;
        step;
        for (int i = 0; i < 4; i++) begin
            do_read(8'(4 * i), d0, rr0, d1, rr1);
            checks++;
            if (d0 !== 32'd0 || rr0 !== 3'd0) begin
                errors++;
                $display("FAIL rstmid_reg%0d: rdata=%h rresp=%0d required 0 0", i, d0, rr0);
            end
        end
    endtask

    task automatic test_base16;
        logic [2:0] r0, r1, rr0, rr1;
        logic [31:0] d0, d1;
        do_write(8'h18, 32'd76, 5'h0F, r0, r1);
        checks++;
        if (r1 !== 3'd0 || r0 !== 3'd2) begin
            errors++;
            $display("FAIL base16_bresp: win16=%0d win0=%0d required 0 2", r1, r0);
        end
        do_read(8'h18, d0, rr0, d1, rr1);
        checks++;
        if (d1 !== 32'd76 || rr1 !== 3'd0) begin
            errors++;
            $display("FAIL base16_read18: rdata=%0d rresp=%0d required 76 0", d1, rr1);
        end
        do_read(8'h10, d0, rr0, d1, rr1);
        checks++;
        if (d1 !== 32'd0) begin
            errors++;
            $display("FAIL base16_reg0: rdata=%0d required 0", d1);
        end
        do_read(8'h0C, d0, rr0, d1, rr1);
        checks++;
        if (rr1 !== 3'd2 || d1 !== 32'd0 || rr0 !== 3'd0) begin
            errors++;
            $display("FAIL base16_oob0c: rresp16=%0d rdata16=%h rresp0=%0d required 2 0 0", rr1, d1, rr0);
        end
    endtask

    task automatic test_concurrent;
        logic [2:0] rr0, rr1;
        logic [31:0] d0, d1;
        awaddr = 8'h00; wdata = 32'h55; wstrb = 5'h0F; awvalid = 1; wvalid = 1; bready = 1;
        araddr = 8'h00; arvalid = 1; rready = 1;
        step;
        awvalid = 0; wvalid = 0; arvalid = 0;
        checks++;
        if ({bvalid0, rvalid0} !== 2'b11 || rdata0 !== 32'd0) begin
            errors++;
            $display("FAIL concurrent_old: bvalid=%b rvalid=%b rdata=%h required 1 1 0", bvalid0, rvalid0, rdata0);
        end
        step;
        do_read(8'h00, d0, rr0, d1, rr1);
        checks++;
        if (d0 !== 32'h55) begin
            errors++;
            $display("FAIL concurrent_new: rdata=%h required 55", d0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_strobe;
        test_aw_first;
        test_oob;
        test_backpressure;
        test_reset_mid;
        test_base16;
        test_concurrent;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
